// File: rtl/bsg_link_pkg.sv
// Shared widths and types for the BSG two-channel link receive path.
// Optional sticky overflow flag in the top is enabled by BSG_DOWNSTREAM_ERR_EN.
package bsg_link_pkg;

  localparam int CH_W           = 8;
  localparam int BEAT_W         = 16;
  localparam int WORD_W         = 64;
  localparam int BEATS_PER_WORD = 4;

  typedef enum logic [1:0] {
    BEAT0 = 2'd0,
    BEAT1 = 2'd1,
    BEAT2 = 2'd2,
    BEAT3 = 2'd3
  } beat_state_e;

  typedef logic [WORD_W-1:0] link_word_t;

endpackage

// File: rtl/bsg_link_rx_fifo.sv
// Small word FIFO between the beat assembler and the core; head word is read
// straight from storage, a write while full is taken only if the head is popped.
module bsg_link_rx_fifo
  import bsg_link_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en_i,
  input  link_word_t wr_data_i,
  input  logic       yumi_i,
  output logic       valid_o,
  output link_word_t data_o,
  output logic       full_o
);

  localparam int PTR_W = $clog2(DEPTH);

  link_word_t       mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_rd, do_wr;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign valid_o = (count_q != '0);
  assign data_o  = mem_q[rd_ptr_q];

  // Full uses the pre-edge count, so a same-cycle pop frees the slot being written.
  assign do_rd = yumi_i & valid_o;
  assign do_wr = wr_en_i & (~full_o | do_rd);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_rd) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/bsg_downstream_link_rx.sv
// Receive end of the BSG link: assembles four 16-bit beats into a 64-bit word,
// buffers words, returns one credit per consumed word. Option: BSG_DOWNSTREAM_ERR_EN.
module bsg_downstream_link_rx
  import bsg_link_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              io_valid_in,
  input  logic [CH_W-1:0]   io_data_in_ch0,
  input  logic [CH_W-1:0]   io_data_in_ch1,
  output logic              io_token_out,
  output logic              core_valid_out,
  output logic [WORD_W-1:0] core_data_out,
  input  logic              core_yumi_in
`ifdef BSG_DOWNSTREAM_ERR_EN
  ,
  output logic              err_overflow
`endif
);

  localparam int SHIFT_W = (BEATS_PER_WORD - 1) * BEAT_W;

  beat_state_e        state_q, state_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic               token_q, token_d;
  logic [BEAT_W-1:0]  beat;
  logic               word_done;
  link_word_t         wr_word;
  logic               fifo_valid, fifo_full;
  logic               yumi_ok;

  assign beat    = {io_data_in_ch1, io_data_in_ch0};
  // Earlier beats sit in the low bits; the final beat lands on top.
  assign wr_word = {beat, shift_q};
  assign yumi_ok = core_yumi_in & fifo_valid;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    word_done = 1'b0;
    if (io_valid_in) begin
      case (state_q)
        BEAT0:   state_d = BEAT1;
        BEAT1:   state_d = BEAT2;
        BEAT2:   state_d = BEAT3;
        default: state_d = BEAT0;
      endcase
      if (state_q == BEAT3) word_done = 1'b1;
      else                  shift_d   = {beat, shift_q[SHIFT_W-1:BEAT_W]};
    end
    token_d = yumi_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BEAT0;
      shift_q <= '0;
      token_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      token_q <= token_d;
    end
  end

  assign io_token_out = token_q;

  bsg_link_rx_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en_i  (word_done),
    .wr_data_i(wr_word),
    .yumi_i   (core_yumi_in),
    .valid_o  (fifo_valid),
    .data_o   (core_data_out),
    .full_o   (fifo_full)
  );

  assign core_valid_out = fifo_valid;

`ifdef BSG_DOWNSTREAM_ERR_EN
  logic overflow;
  logic err_q, err_d;

  assign overflow = word_done & fifo_full & ~yumi_ok;

  always_comb begin
    err_d = err_q | overflow;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err_overflow = err_q;

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n) !overflow);
`endif

endmodule
